// File: rtl/sc_spi_pkg.sv
// Shared types and constants for the SPI engine arbiter.
// Holds the sequencer states, the datapath widths and an index-width helper.
package sc_spi_pkg;

  localparam int SPI_DW_W   = 9;
  localparam int SPI_DATA_W = 32;
  localparam int NREQ_MAX   = 8;

  typedef enum logic [2:0] {
    IDLE,
    STRT,
    WBSY,
    XFER,
    HOLD
  } state_t;

  // Never returns less than 1, so a counter or an index always has at least one bit.
  function automatic int clog2(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << r) < n) r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sc_spi_rrarb.sv
// Combinational round-robin picker.
// The search starts at the requester just after the pointer and wraps around.
module sc_spi_rrarb
  import sc_spi_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IW   = clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IW-1:0]   i_ptr,
  output logic [NREQ-1:0] o_gnt,
  output logic [IW-1:0]   o_idx,
  output logic            o_any
);

  logic [IW-1:0] w_cand;

  always_comb begin
    o_gnt  = '0;
    o_idx  = '0;
    o_any  = 1'b0;
    w_cand = '0;
    for (int k = 1; k <= NREQ; k++) begin
      w_cand = IW'((int'(i_ptr) + k) % NREQ);
      if (!o_any && i_req[w_cand]) begin
        o_any         = 1'b1;
        o_idx         = w_cand;
        o_gnt[w_cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sc_spi_arb.sv
// Shares one SPI protocol engine between NREQ requesters.
// Round-robin grant, start/busy sequencing, lock-driven CS extension and RX routing.
module sc_spi_arb
  import sc_spi_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int BSY_TMO = 4
) (
  input  logic                       i_spiclk,
  input  logic                       i_sysrst,
  input  logic [NREQ-1:0]            i_req,
  input  logic [NREQ-1:0]            i_req_lock,
  input  logic [NREQ*SPI_DW_W-1:0]   i_req_dwidth,
  input  logic [NREQ-1:0]            i_req_border,
  input  logic [NREQ*SPI_DATA_W-1:0] i_req_txdata,
  output logic [NREQ-1:0]            o_gnt,
  output logic [NREQ-1:0]            o_done,
  output logic [NREQ-1:0]            o_req_rxvalid,
  output logic                       o_err,
  output logic                       o_spistart,
  output logic                       o_csextend,
  output logic [SPI_DW_W-1:0]        o_dwidth,
  output logic                       o_border,
  output logic [SPI_DATA_W-1:0]      o_txdata,
  input  logic                       i_spibusy,
  input  logic                       i_rxvalid
);

  localparam int IW = clog2(NREQ);
  localparam int CW = clog2(BSY_TMO + 1);

  state_t            r_state, w_nstate;
  logic [IW-1:0]     r_owner, w_nowner, r_rrptr, w_nrrptr, w_pickIdx;
  logic [CW-1:0]     r_cnt, w_ncnt;
  logic [NREQ-1:0]   r_gnt, w_ngnt, r_done, w_ndone, w_pickGnt;
  logic              r_err, w_nerr, w_pickAny, w_granted;
  logic              w_lock, w_req, w_border;
  logic [SPI_DW_W-1:0]   w_dwidth;
  logic [SPI_DATA_W-1:0] w_txdata;

  sc_spi_rrarb #(.NREQ(NREQ), .IW(IW)) u_rrarb (
    .i_req (i_req),
    .i_ptr (r_rrptr),
    .o_gnt (w_pickGnt),
    .o_idx (w_pickIdx),
    .o_any (w_pickAny)
  );

  always_comb begin
    w_lock   = 1'b0;
    w_req    = 1'b0;
    w_border = 1'b0;
    w_dwidth = '0;
    w_txdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (r_owner == IW'(i)) begin
        w_lock   = i_req_lock[i];
        w_req    = i_req[i];
        w_border = i_req_border[i];
        w_dwidth = i_req_dwidth[i*SPI_DW_W +: SPI_DW_W];
        w_txdata = i_req_txdata[i*SPI_DATA_W +: SPI_DATA_W];
      end
    end
  end

  always_ff @(posedge i_spiclk or posedge i_sysrst) begin
    if (i_sysrst) begin
      r_state <= IDLE;
      r_owner <= '0;
      r_rrptr <= IW'(NREQ - 1);
      r_cnt   <= '0;
      r_gnt   <= '0;
      r_done  <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_nstate;
      r_owner <= w_nowner;
      r_rrptr <= w_nrrptr;
      r_cnt   <= w_ncnt;
      r_gnt   <= w_ngnt;
      r_done  <= w_ndone;
      r_err   <= w_nerr;
    end
  end

  // DONE and ERR are one-cycle pulses, so they default low every cycle.
  always_comb begin
    w_nstate = r_state;
    w_nowner = r_owner;
    w_nrrptr = r_rrptr;
    w_ncnt   = r_cnt;
    w_ngnt   = r_gnt;
    w_ndone  = '0;
    w_nerr   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_pickAny) begin
          w_nowner = w_pickIdx;
          w_nrrptr = w_pickIdx;
          w_ngnt   = w_pickGnt;
          w_nstate = STRT;
        end
      end
      STRT: begin
        w_ncnt   = '0;
        w_nstate = WBSY;
      end
      WBSY: begin
        if (i_spibusy) begin
          w_nstate = XFER;
        end else if (r_cnt == CW'(BSY_TMO - 1)) begin
          w_nerr   = 1'b1;
          w_ndone  = r_gnt;
          w_ngnt   = '0;
          w_nstate = IDLE;
        end else begin
          w_ncnt = r_cnt + CW'(1);
        end
      end
      XFER: begin
        if (!i_spibusy) begin
          w_ndone = r_gnt;
          if (w_lock) begin
            w_nstate = HOLD;
          end else begin
            w_ngnt   = '0;
            w_nstate = IDLE;
          end
        end
      end
      HOLD: begin
        if (!w_lock) begin
          w_ngnt   = '0;
          w_nstate = IDLE;
        end else if (w_req) begin
          w_nstate = STRT;
        end
      end
      default: begin
        w_ngnt   = '0;
        w_nstate = IDLE;
      end
    endcase
  end

  assign w_granted     = |r_gnt;
  assign o_gnt         = r_gnt;
  assign o_done        = r_done;
  assign o_err         = r_err;
  assign o_spistart    = (r_state == STRT);
  assign o_csextend    = w_granted & w_lock;
  assign o_dwidth      = w_granted ? w_dwidth : '0;
  assign o_border      = w_granted & w_border;
  assign o_txdata      = w_txdata;
  assign o_req_rxvalid = ((r_state == WBSY || r_state == XFER) && i_rxvalid) ? r_gnt : '0;

endmodule

// File: tb/tb_sc_spi_arb.sv
// Self-checking bench for sc_spi_arb with a small SPI engine model.
// Expected owners come from a cyclic-search reference model of the arbitration rules.
module tb_sc_spi_arb;

  localparam int NREQ    = 4;
  localparam int IW      = 2;
  localparam int BSY_TMO = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req, lock, borderIn;
  logic [8:0]        dwArr [NREQ];
  logic [31:0]       txArr [NREQ];
  logic [NREQ*9-1:0] reqDwidth;
  logic [NREQ*32-1:0] reqTxdata;
  logic [NREQ-1:0]   gnt, done, reqRxvalid;
  logic              err, spistart, csextend, borderOut;
  logic [8:0]        dwidthOut;
  logic [31:0]       txdataOut;
  logic              spibusy, rxvalid;
  int                busyLeft, busyLen;
  bit                engineEn;
  int                checks = 0;
  int                failures = 0;
  int                mPtr;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NREQ; g++) begin : gPack
    assign reqDwidth[g*9 +: 9]   = dwArr[g];
    assign reqTxdata[g*32 +: 32] = txArr[g];
  end

  sc_spi_arb #(.NREQ(NREQ), .BSY_TMO(BSY_TMO)) dut (
    .i_spiclk      (clk),
    .i_sysrst      (rst),
    .i_req         (req),
    .i_req_lock    (lock),
    .i_req_dwidth  (reqDwidth),
    .i_req_border  (borderIn),
    .i_req_txdata  (reqTxdata),
    .o_gnt         (gnt),
    .o_done        (done),
    .o_req_rxvalid (reqRxvalid),
    .o_err         (err),
    .o_spistart    (spistart),
    .o_csextend    (csextend),
    .o_dwidth      (dwidthOut),
    .o_border      (borderOut),
    .o_txdata      (txdataOut),
    .i_spibusy     (spibusy),
    .i_rxvalid     (rxvalid)
  );

  // Engine model: busy rises the edge after it sees SPISTART and stays up busyLen cycles.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      spibusy  <= 1'b0;
      busyLeft <= 0;
    end else if (spistart && engineEn) begin
      spibusy  <= 1'b1;
      busyLeft <= busyLen - 1;
    end else if (spibusy) begin
      if (busyLeft == 0) spibusy <= 1'b0;
      else busyLeft <= busyLeft - 1;
    end
  end
  assign rxvalid = spibusy && (busyLeft == 0);

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [NREQ-1:0] r, input logic [NREQ-1:0] l);
    req  = r;
    lock = l;
  endtask

  task automatic doReset();
    applyStimulus('0, '0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst  = 1'b0;
    mPtr = NREQ - 1;
  endtask

  function automatic int rrPick(input logic [NREQ-1:0] r, input int p);
    logic [NREQ-1:0] s;
    for (int k = 1; k <= NREQ; k++) begin
      s = r >> ((p + k) % NREQ);
      if (s[0]) return (p + k) % NREQ;
    end
    return -1;
  endfunction

  function automatic logic [NREQ-1:0] hot(input int i);
    return NREQ'(1) << i;
  endfunction

  // One full segment for expOwner: grant, start pulse, mux, RX routing, busy-to-DONE gap.
  task automatic runSegment(input int expOwner, input string tag, input bit csChk,
                            input logic csExp, input int dropAt, output int lat);
    logic [IW-1:0] ix;
    bit seen, chkCs;
    int n, rxBad, rxSeen, csBad, busyLastN;
    ix = IW'(expOwner);
    lat = 0; seen = 0;
    while (!seen && lat < 20) begin
      @(negedge clk);
      lat++;
      if (gnt != '0) seen = 1;
    end
    if (!seen) begin
      checkOutput({tag, "_gntTimeout"}, 64'(0), 64'(1));
      return;
    end
    checkOutput({tag, "_gnt"}, 64'(gnt), 64'(hot(expOwner)));
    checkOutput({tag, "_start"}, 64'(spistart), 64'(1));
    checkOutput({tag, "_mux"}, 64'({dwidthOut, borderOut, txdataOut}),
                64'({dwArr[ix], borderIn[ix], txArr[ix]}));
    @(negedge clk);
    checkOutput({tag, "_startWidth"}, 64'(spistart), 64'(0));
    n = 0; seen = 0; rxBad = 0; rxSeen = 0; csBad = 0; busyLastN = -100; chkCs = csChk;
    while (!seen && n < 200) begin
      if (n == dropAt) begin
        lock[ix] = 1'b0;
        chkCs = 0;
      end
      if (rxvalid) begin
        rxSeen++;
        if (reqRxvalid !== hot(expOwner)) rxBad++;
      end
      if (chkCs && (csextend !== csExp || gnt !== hot(expOwner))) csBad++;
      if (err) rxBad++;
      if (spibusy) busyLastN = n;
      @(negedge clk);
      n++;
      if (done != '0) seen = 1;
    end
    if (!seen) begin
      checkOutput({tag, "_doneTimeout"}, 64'(0), 64'(1));
      return;
    end
    checkOutput({tag, "_done"}, 64'(done), 64'(hot(expOwner)));
    checkOutput({tag, "_rxRoute"}, 64'(rxBad), 64'(0));
    checkOutput({tag, "_rxSeen"}, 64'(rxSeen), 64'(1));
    checkOutput({tag, "_busyToDone"}, 64'(n - busyLastN - 1), 64'(1));
    if (csChk) checkOutput({tag, "_csHeld"}, 64'(csBad), 64'(0));
    mPtr = expOwner;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int lat, bad, e;
    bit seen;
    rst = 1'b1;
    engineEn = 1'b1;
    busyLen = 40;
    for (int i = 0; i < NREQ; i++) begin
      dwArr[i] = 9'($urandom);
      txArr[i] = $urandom;
    end
    borderIn = NREQ'($urandom);
    dwArr[0] = 9'd31;
    doReset();

    $display("[TB] reset state");
    checkOutput("rst_outs", 64'({gnt, done, reqRxvalid, err, spistart, csextend}), 64'(0));
    checkOutput("rst_dwidth", 64'(dwidthOut), 64'(0));
    checkOutput("rst_txmux", 64'(txdataOut), 64'(txArr[0]));

    $display("[TB] single request");
    applyStimulus(4'b0001, 4'b0000);
    runSegment(rrPick(req, mPtr), "single", 1, 1'b0, -1, lat);
    checkOutput("single_latency", 64'(lat), 64'(1));
    applyStimulus(4'b0000, 4'b0000);
    @(negedge clk);
    checkOutput("single_gntAfter", 64'(gnt), 64'(0));

    $display("[TB] round robin");
    doReset();
    applyStimulus(4'b1111, 4'b0000);
    for (int s = 0; s < 5; s++) begin
      busyLen = $urandom_range(1, 12);
      e = rrPick(req, mPtr);
      runSegment(e, "rr", 0, 1'b0, -1, lat);
      checkOutput("rr_order", 64'(mPtr), 64'(s % NREQ));
    end
    applyStimulus(4'b0000, 4'b0000);

    $display("[TB] lock");
    doReset();
    busyLen = 6;
    applyStimulus(4'b0100, 4'b0100);
    @(posedge clk);
    #1 req = 4'b1111;
    runSegment(2, "lock1", 1, 1'b1, -1, lat);
    runSegment(2, "lock2", 1, 1'b1, -1, lat);
    runSegment(2, "lock3", 1, 1'b1, 3, lat);
    checkOutput("lock3_csEnd", 64'(csextend), 64'(0));
    checkOutput("lock3_gntEnd", 64'(gnt), 64'(0));
    applyStimulus(4'b1011, 4'b0000);
    runSegment(rrPick(req, mPtr), "lockNext", 0, 1'b0, -1, lat);
    checkOutput("lockNext_owner", 64'(mPtr), 64'(3));
    applyStimulus(4'b0000, 4'b0000);

    $display("[TB] hold release");
    doReset();
    busyLen = $urandom_range(2, 8);
    applyStimulus(4'b0001, 4'b0001);
    runSegment(0, "hold", 1, 1'b1, -1, lat);
    applyStimulus(4'b0000, 4'b0001);
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (gnt !== 4'b0001 || spistart !== 1'b0 || csextend !== 1'b1) bad++;
    end
    checkOutput("hold_kept", 64'(bad), 64'(0));
    applyStimulus(4'b0000, 4'b0000);
    #1 checkOutput("hold_csDrop", 64'(csextend), 64'(0));
    @(negedge clk);
    checkOutput("hold_release", 64'(gnt), 64'(0));

    $display("[TB] busy timeout");
    doReset();
    engineEn = 1'b0;
    applyStimulus(4'b0010, 4'b0000);
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      if (spistart) seen = 1;
    end
    checkOutput("tmo_start", 64'(seen), 64'(1));
    bad = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (err !== 1'b0 || done !== 4'b0000 || gnt !== 4'b0010) bad++;
    end
    checkOutput("tmo_wait", 64'(bad), 64'(0));
    @(negedge clk);
    checkOutput("tmo_err", 64'(err), 64'(1));
    checkOutput("tmo_done", 64'(done), 64'(4'b0010));
    checkOutput("tmo_gnt", 64'(gnt), 64'(0));
    mPtr = 1;
    applyStimulus(4'b0000, 4'b0000);
    @(negedge clk);
    checkOutput("tmo_errPulse", 64'(err), 64'(0));
    engineEn = 1'b1;
    busyLen = 4;
    applyStimulus(4'b0100, 4'b0000);
    runSegment(rrPick(req, mPtr), "tmoNext", 0, 1'b0, -1, lat);
    applyStimulus(4'b0000, 4'b0000);

    $display("[TB] reset mid-transfer");
    doReset();
    busyLen = 40;
    applyStimulus(4'b0001, 4'b0001);
    repeat (6) @(negedge clk);
    checkOutput("mid_preGnt", 64'({gnt, csextend, spibusy}), 64'({4'b0001, 1'b1, 1'b1}));
    #2 rst = 1'b1;
    #1 checkOutput("mid_async", 64'({gnt, spistart, csextend, done, reqRxvalid}), 64'(0));
    @(negedge clk);
    rst  = 1'b0;
    mPtr = NREQ - 1;
    busyLen = 3;
    applyStimulus(4'b1111, 4'b0000);
    runSegment(rrPick(req, mPtr), "postRst", 0, 1'b0, -1, lat);
    checkOutput("postRst_owner", 64'(mPtr), 64'(0));
    applyStimulus(4'b0000, 4'b0000);

    $display("[TB] random traffic");
    doReset();
    for (int round = 0; round < 4; round++) begin
      logic [NREQ-1:0] r;
      int guard;
      r = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      guard = 0;
      applyStimulus(r, '0);
      while (r != '0 && guard < 12) begin
        e = rrPick(r, mPtr);
        busyLen = $urandom_range(1, 10);
        runSegment(e, "rand", 0, 1'b0, -1, lat);
        guard++;
        if ($urandom_range(0, 1) == 1) r[IW'(e)] = 1'b0;
        applyStimulus(r, '0);
      end
      applyStimulus('0, '0);
      repeat (3) @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
